// File: rtl/fm_mod_pkg.sv
// rtl/fm_mod_pkg.sv - shared constants, FSM state type and sine-table generator for fm_mod
package fm_mod_pkg;
   localparam int QUANT_BITS = 10;
   localparam int LUT_BITS   = 10;
   localparam int LUT_DEPTH  = 2**LUT_BITS;
   localparam int QUARTER    = 2**(LUT_BITS-2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_LUT,
      S_WRITE
   } state_t;

   // Round half away from zero so the table is symmetric about the axis.
   function automatic logic signed [31:0] sin_entry(input int k);
      real ang;
      real v;
      int  r;
      ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_DEPTH);
      v   = real'(1 << QUANT_BITS) * $sin(ang);
      if (v >= 0.0) r = $rtoi(v + 0.5);
      else          r = -$rtoi(0.5 - v);
      return r;
   endfunction
endpackage

// File: rtl/fm_sincos_lut.sv
// rtl/fm_sincos_lut.sv - dual-read sine ROM with registered sin/cos outputs
module fm_sincos_lut
   import fm_mod_pkg::*;
(
   input  logic                clk,
   input  logic [LUT_BITS-1:0] sin_idx,
   input  logic [LUT_BITS-1:0] cos_idx,
   output logic signed [31:0]  sin_val,
   output logic signed [31:0]  cos_val
);
   logic signed [31:0] rom [LUT_DEPTH];
   logic signed [31:0] sin_q;
   logic signed [31:0] cos_q;

   initial begin
      for (int k = 0; k < LUT_DEPTH; k++) rom[k] = sin_entry(k);
   end

   always_ff @(posedge clk) begin
      sin_q <= rom[sin_idx];
      cos_q <= rom[cos_idx];
   end

   assign sin_val = sin_q;
   assign cos_val = cos_q;
endmodule

// File: rtl/fm_mod.sv
// rtl/fm_mod.sv - FM modulator: integrates samples into a phase accumulator and emits Q10 cos/sin
module fm_mod
   import fm_mod_pkg::*;
#(
   parameter int signed GAIN = 1
)(
   input  logic               clk,
   input  logic               reset,
   input  logic signed [31:0] in_dout,
   input  logic               in_empty,
   output logic               in_rd_en,
   input  logic               out_full,
   output logic               out_wr_en,
   output logic signed [31:0] real_din,
   output logic signed [31:0] imag_din
);
   state_t             state_q, state_d;
   logic [31:0]        phase_q, phase_d;
   logic signed [31:0] sample_q, sample_d;
   logic signed [31:0] real_q, real_d;
   logic signed [31:0] imag_q, imag_d;
   logic [31:0]        phase_inc;
   logic [LUT_BITS-1:0] sin_idx;
   logic [LUT_BITS-1:0] cos_idx;
   logic signed [31:0] sin_val;
   logic signed [31:0] cos_val;

   // Only the low 32 bits of the product matter, so a 32-bit multiply suffices.
   assign phase_inc = sample_q * GAIN;
   assign sin_idx   = phase_q[31 -: LUT_BITS];
   assign cos_idx   = sin_idx + LUT_BITS'(QUARTER);

   fm_sincos_lut u_lut (
      .clk     (clk),
      .sin_idx (sin_idx),
      .cos_idx (cos_idx),
      .sin_val (sin_val),
      .cos_val (cos_val)
   );

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      sample_d  = sample_q;
      real_d    = real_q;
      imag_d    = imag_q;
      in_rd_en  = 1'b0;
      out_wr_en = 1'b0;
      real_din  = real_q;
      imag_din  = imag_q;
      case (state_q)
         S_IDLE: begin
            if (!in_empty) begin
               in_rd_en = 1'b1;
               sample_d = in_dout;
               state_d  = S_ACCUM;
            end
         end
         S_ACCUM: begin
            phase_d = phase_q + phase_inc;
            state_d = S_LUT;
         end
         S_LUT: begin
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (!out_full) begin
               out_wr_en = 1'b1;
               real_d    = cos_val;
               imag_d    = sin_val;
               real_din  = cos_val;
               imag_din  = sin_val;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Strobes stay quiet in the reset cycle so nothing is half-popped or half-written.
      if (reset) begin
         in_rd_en  = 1'b0;
         out_wr_en = 1'b0;
         real_din  = real_q;
         imag_din  = imag_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         phase_q  <= '0;
         sample_q <= '0;
         real_q   <= '0;
         imag_q   <= '0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         sample_q <= sample_d;
         real_q   <= real_d;
         imag_q   <= imag_d;
      end
   end
endmodule

// File: tb/tb_fm_mod.sv
// tb/tb_fm_mod.sv - self-checking bench for fm_mod against a phase/sine model
module tb_fm_mod;
   localparam int signed GAIN_TB = 1;
   localparam real PI = 3.14159265358979323846;

   logic               clk;
   logic               reset;
   logic signed [31:0] in_dout;
   logic               in_empty;
   logic               in_rd_en;
   logic               out_full;
   logic               out_wr_en;
   logic signed [31:0] real_din;
   logic signed [31:0] imag_din;

   fm_mod #(.GAIN(GAIN_TB)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_dout   (in_dout),
      .in_empty  (in_empty),
      .in_rd_en  (in_rd_en),
      .out_full  (out_full),
      .out_wr_en (out_wr_en),
      .real_din  (real_din),
      .imag_din  (imag_din)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int rd_cyc = 0;
   int wr_count = 0;
   int n_pops = 0;
   bit pending = 0;
   bit stalled = 0;
   bit pop_req = 0;
   logic [31:0] m_phase = '0;
   logic [31:0] last_re = '0;
   logic [31:0] last_im = '0;
   logic [31:0] fifo[$];
   logic [31:0] exp_re[$];
   logic [31:0] exp_im[$];
   logic [31:0] got_re[$];
   logic [31:0] got_im[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   function automatic logic [31:0] ref_sin(input int k);
      real v;
      v = 1024.0 * $sin(2.0 * PI * real'(k) / 1024.0);
      if (v >= 0.0) return 32'($rtoi(v + 0.5));
      else          return 32'(-$rtoi(0.5 - v));
   endfunction

   // Upstream FWFT FIFO: pops land just after the edge that consumed the head.
   initial begin
      in_empty = 1'b1;
      in_dout  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (pop_req) begin
            void'(fifo.pop_front());
            pop_req = 0;
         end
         in_empty = (fifo.size() == 0);
         in_dout  = in_empty ? 32'sd0 : fifo[0];
      end
   end

   // Model and per-cycle compare.
   initial begin
      int k;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            m_phase = '0;
            exp_re.delete();
            exp_im.delete();
            pending = 0;
            stalled = 0;
            pop_req = 0;
            last_re = '0;
            last_im = '0;
         end else begin
            chk("rd_wr_exclusive", {31'b0, in_rd_en & out_wr_en}, 32'd0);
            if (in_rd_en) begin
               chk("pop_while_pending", {31'b0, pending}, 32'd0);
               m_phase = m_phase + 32'(in_dout * GAIN_TB);
               k = int'(m_phase[31:22]);
               exp_re.push_back(ref_sin((k + 256) % 1024));
               exp_im.push_back(ref_sin(k));
               pending = 1;
               stalled = 0;
               rd_cyc  = cyc;
               pop_req = 1;
               n_pops++;
            end
            if (out_full) begin
               chk("write_under_full", {31'b0, out_wr_en}, 32'd0);
               if (pending) stalled = 1;
            end
            if (out_wr_en) begin
               if (exp_re.size() == 0) begin
                  chk("unexpected_write", 32'd1, 32'd0);
               end else begin
                  chk("real_din", real_din, exp_re.pop_front());
                  chk("imag_din", imag_din, exp_im.pop_front());
               end
               if (!stalled) chk("latency", 32'(cyc - rd_cyc), 32'd3);
               pending = 0;
               last_re = real_din;
               last_im = imag_din;
               got_re.push_back(real_din);
               got_im.push_back(imag_din);
               wr_count++;
            end else begin
               chk("real_hold", real_din, last_re);
               chk("imag_hold", imag_din, last_im);
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      fifo.delete();
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic push(input logic [31:0] v);
      fifo.push_back(v);
   endtask

   task automatic wait_writes(input int n, input int budget);
      int c = 0;
      while (wr_count < n && c < budget) begin
         @(posedge clk);
         c++;
      end
      chk("writes_seen", 32'(wr_count), 32'(n));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int p0;
      int c;
      reset    = 1'b1;
      out_full = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_rd_en", {31'b0, in_rd_en}, 32'd0);
      chk("reset_wr_en", {31'b0, out_wr_en}, 32'd0);
      chk("reset_real", real_din, 32'd0);
      chk("reset_imag", imag_din, 32'd0);

      // Zero sample from reset.
      base = wr_count;
      push(32'h0000_0000);
      wait_writes(base + 1, 40);
      chk("zero_re", got_re[base], 32'h0000_0400);
      chk("zero_im", got_im[base], 32'h0000_0000);

      // Quarter-turn steps around the circle.
      do_reset();
      base = wr_count;
      repeat (4) push(32'h4000_0000);
      wait_writes(base + 4, 80);
      chk("q1_re", got_re[base],   32'h0000_0000);
      chk("q1_im", got_im[base],   32'h0000_0400);
      chk("q2_re", got_re[base+1], 32'hFFFF_FC00);
      chk("q2_im", got_im[base+1], 32'h0000_0000);
      chk("q3_re", got_re[base+2], 32'h0000_0000);
      chk("q3_im", got_im[base+2], 32'hFFFF_FC00);
      chk("q4_re", got_re[base+3], 32'h0000_0400);
      chk("q4_im", got_im[base+3], 32'h0000_0000);

      // Negative increment.
      do_reset();
      base = wr_count;
      push(32'hC000_0000);
      wait_writes(base + 1, 40);
      chk("neg_re", got_re[base], 32'h0000_0000);
      chk("neg_im", got_im[base], 32'hFFFF_FC00);

      // Backpressure with three samples queued.
      do_reset();
      out_full = 1'b1;
      base = wr_count;
      p0   = n_pops;
      push(32'h1000_0000);
      push(32'h2000_0000);
      push(32'h3000_0000);
      repeat (12) @(posedge clk);
      chk("stall_no_write", 32'(wr_count), 32'(base));
      chk("stall_one_pop", 32'(n_pops), 32'(p0 + 1));
      #1 out_full = 1'b0;
      @(negedge clk);
      chk("write_on_release", {31'b0, out_wr_en}, 32'd1);
      wait_writes(base + 3, 60);
      chk("bp1_re", got_re[base],   32'h0000_03B2);
      chk("bp1_im", got_im[base],   32'h0000_0188);
      chk("bp2_re", got_re[base+1], 32'h0000_0188);
      chk("bp2_im", got_im[base+1], 32'h0000_03B2);
      chk("bp3_re", got_re[base+2], 32'hFFFF_FD2C);
      chk("bp3_im", got_im[base+2], 32'h0000_02D4);

      // Reset while the sample sits in the LUT stage.
      do_reset();
      base = wr_count;
      p0   = n_pops;
      push(32'h4000_0000);
      c = 0;
      while (n_pops == p0 && c < 50) begin
         @(posedge clk);
         c++;
      end
      chk("mid_pop_seen", 32'(n_pops), 32'(p0 + 1));
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (6) @(posedge clk);
      chk("mid_reset_no_write", 32'(wr_count), 32'(base));
      push(32'h0000_0000);
      wait_writes(base + 1, 40);
      chk("mid_reset_re", got_re[base], 32'h0000_0400);
      chk("mid_reset_im", got_im[base], 32'h0000_0000);

      // Longer stream with random backpressure; the model checks every write.
      do_reset();
      base = wr_count;
      for (int i = 0; i < 100; i++) push(32'(i) * 32'h0A3D_70A5 + 32'h0123_4567);
      c = 0;
      while (wr_count < base + 100 && c < 3000) begin
         @(posedge clk);
         #1 out_full = ($urandom_range(0, 3) == 0);
         c++;
      end
      out_full = 1'b0;
      wait_writes(base + 100, 20);
      chk("stream_fifo_drained", 32'(fifo.size()), 32'd0);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fm_mod.md
Name: fm_mod

Overview:
Baseband FM modulator; the transmit-side inverse of demod_top. It pops 32-bit signed audio/deviation samples from an upstream FWFT FIFO and integrates them into a 32-bit phase accumulator. Each sample produces one complex Q10 sample (cos, sin of the accumulated phase), written to the real/imag FIFO pair. Its output feeds a loopback of demod_top (fm_mod -> FIFOs -> demod_top) and a synthetic I/Q generator for system tests.

Parameters:
QUANT_BITS, 10, fixed-point fraction bits; amplitude 1.0 = 1 << QUANT_BITS = 1024.
LUT_BITS, 10, log2 of sine table depth; phase index = phase[31 -: LUT_BITS].
GAIN, 1, signed 32-bit multiplier; phase_inc = low 32 bits of (sample * GAIN).

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
in_dout  in  32  signed sample from input FIFO; FWFT, so valid whenever in_empty=0.
in_empty  in  1  input FIFO empty.
in_rd_en  out  1  input FIFO pop, one-cycle pulse.
out_full  in  1  OR of real/imag FIFO full flags.
out_wr_en  out  1  write strobe, common to both output FIFOs.
real_din  out  32  signed Q10 cos(phase).
imag_din  out  32  signed Q10 sin(phase).

Behaviour:
- Reset is synchronous and active-high. It applies to the single clk domain. On reset: state=S_IDLE, phase=0, in_rd_en=0, out_wr_en=0, real_din=0, imag_din=0, sample register=0.
- FSM states: S_IDLE, S_ACCUM, S_LUT, S_WRITE.
- S_IDLE: if in_empty=0, assert in_rd_en for 1 cycle, latch in_dout into the sample register, and go to S_ACCUM. Otherwise stay in S_IDLE with in_rd_en=0.
- S_ACCUM: phase <= phase + (sample*GAIN)[31:0]. Signed multiply, truncated to 32 bits. Unsigned modulo-2^32 add, so wrap-around is the intended 2*pi wrap. Go to S_LUT.
- S_LUT: present sin_idx = phase[31 -: LUT_BITS] and cos_idx = sin_idx + 2^(LUT_BITS-2) (mod 2^LUT_BITS) to the LUT. LUT outputs are registered and valid next cycle. Go to S_WRITE.
- S_WRITE: if out_full=0, assert out_wr_en for 1 cycle, drive real_din=cos value and imag_din=sin value, and go to S_IDLE. If out_full=1, hold all state, keep out_wr_en=0, and retry every cycle.
- Output phase convention: output n uses the phase after adding sample n. The first output after reset with sample 0 is (1024, 0).
- Throughput: 1 sample per 4 cycles minimum. Latency is 3 cycles from the in_rd_en cycle to the out_wr_en cycle when out_full=0.
- in_rd_en and out_wr_en are never asserted in the same cycle.
- No pop occurs while a sample is pending, so backpressure propagates upstream with no loss.
- real_din and imag_din hold their last written values between writes.
- LUT contents: sin[k] = round(1024*sin(2*pi*k/2^LUT_BITS)), sign-extended to 32 bits. Entries at exact quarter points are 0, ±1024.
- Reset mid-operation: abandons any sample in flight with no partial write, and clears phase to 0.
- in_empty is sampled only in S_IDLE. out_full is sampled only in S_WRITE.

Decomposition:
- Package fm_mod_pkg holds:
  - QUANT_BITS, LUT_BITS, QUARTER = 2**(LUT_BITS-2);
  - the state_t enum {S_IDLE, S_ACCUM, S_LUT, S_WRITE};
  - the function that generates the sine table, used by the sub-module's initial block.
- Sub-module fm_sincos_lut is a dual-read ROM. Inputs: clk, sin_idx, cos_idx. Outputs: registered sin_val and cos_val, both 32-bit signed.

Test Plan:
- Reset, then push 0x00000000 (GAIN=1) -> one write with real_din=0x00000400, imag_din=0x00000000; in_rd_en to out_wr_en = 3 cycles.
- Push 0x40000000 four times -> outputs in order:
  - (0x00000000, 0x00000400);
  - (0xFFFFFC00, 0x00000000);
  - (0x00000000, 0xFFFFFC00);
  - (0x00000400, 0x00000000) after phase wraps to 0.
- Push 0xC0000000 from reset -> (0x00000000, 0xFFFFFC00). Confirms signed increment.
- Hold out_full=1 for 6 cycles while in S_WRITE, with 3 samples queued:
  - no out_wr_en and no in_rd_en during the stall;
  - the write fires on the first cycle out_full=0;
  - all 3 outputs arrive in order, with no drops or duplicates.
- Stream 100 samples from fir-style stimulus into fm_mod -> FIFOs -> demod_top loopback -> demod_top output tracks input*GAIN within the LUT quantization tolerance; zero FIFO overflow.
- Assert reset for 1 cycle while in S_LUT after 0x40000000 -> no write for that sample; a subsequent 0x00000000 yields (0x00000400, 0x00000000), proving phase was cleared.
